// File: rtl/feeder_pkg.sv
// Shared types and constants for the west-edge feeder.
// State encoding, per-row instruction codes and gap length.
package feeder_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_EXEC,
    S_DRAIN
  } state_t;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  localparam int GAP_LEN = 1;

endpackage

// File: rtl/skew_line.sv
// Fixed-depth register delay for one row's {inst, data} bundle.
// Depth 0 is a plain wire.
module skew_line #(
  parameter int w     = 6,
  parameter int depth = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [w-1:0] bundle,
  output logic [w-1:0] q
);

  if (depth == 0) begin : g_pass
    logic unused;
    assign unused = clk ^ reset;
    assign q      = bundle;
  end else begin : g_pipe
    logic [w-1:0] pipe [depth];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < depth; i++)
          pipe[i] <= '0;
      end else begin
        pipe[0] <= bundle;
        for (int i = 1; i < depth; i++)
          pipe[i] <= pipe[i-1];
      end
    end

    assign q = pipe[depth-1];
  end

endmodule

// File: rtl/west_feeder.sv
// West-edge feeder: kernel load, gap, execute stream, then
// a drain until the last word has left the per-row skew lines.
module west_feeder
  import feeder_pkg::*;
#(
  parameter int bw     = 4,
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int cnt_bw = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic                start,
  input  logic [cnt_bw-1:0]   num_act,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [row*bw-1:0]   in_data,
  output logic [row*bw-1:0]   out_w,
  output logic [2*row-1:0]    inst_w,
  output logic                busy,
  output logic                done
);

  localparam int LW = $clog2(2*col+1);
  localparam int DW = $clog2(row+1);
  localparam int BB = bw + 2;

  state_t              state;
  logic [LW-1:0]       load_cnt;
  logic [LW-1:0]       load_last;
  logic [cnt_bw-1:0]   exec_cnt;
  logic [cnt_bw-1:0]   n_act;
  logic [DW-1:0]       dcnt;

  logic                fire;
  logic [1:0]          iss_inst;
  logic [row*bw-1:0]   iss_data;
  logic [row*BB-1:0]   stage0;
  logic [row*BB-1:0]   skew_q;

  assign in_ready = (state == S_LOAD) || (state == S_EXEC);
  assign fire     = in_ready && in_valid;

  always_comb begin
    iss_inst = INST_IDLE;
    iss_data = '0;
    unique case (1'b1)
      fire && (state == S_LOAD): begin
        iss_inst = INST_LOAD;
        iss_data = in_data;
      end
      fire && (state == S_EXEC): begin
        iss_inst = INST_EXEC;
        iss_data = in_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      load_cnt  <= '0;
      load_last <= '0;
      exec_cnt  <= '0;
      n_act     <= '0;
      dcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_LOAD;
            busy      <= 1'b1;
            n_act     <= num_act;
            load_cnt  <= '0;
            load_last <= mode ? LW'(2*col-1) : LW'(col-1);
          end
        end
        S_LOAD: begin
          if (fire) begin
            if (load_cnt == load_last) begin
              state    <= S_GAP;
              load_cnt <= '0;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (load_cnt == LW'(GAP_LEN-1)) begin
            load_cnt <= '0;
            exec_cnt <= '0;
            dcnt     <= '0;
            state    <= (n_act == '0) ? S_DRAIN : S_EXEC;
          end else begin
            load_cnt <= load_cnt + 1'b1;
          end
        end
        S_EXEC: begin
          if (fire) begin
            if (exec_cnt == n_act - 1'b1) begin
              state    <= S_DRAIN;
              exec_cnt <= '0;
            end else begin
              exec_cnt <= exec_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // leave once the last word reaches the deepest row
          if (int'(dcnt) + 2 >= row) begin
            state <= S_IDLE;
            dcnt  <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage0 <= '0;
    end else begin
      for (int r = 0; r < row; r++)
        stage0[r*BB +: BB] <= {iss_inst, iss_data[r*bw +: bw]};
    end
  end

  for (genvar r = 0; r < row; r++) begin : g_row
    skew_line #(
      .w     (BB),
      .depth (r)
    ) u_skew (
      .clk    (clk),
      .reset  (reset),
      .bundle (stage0[r*BB +: BB]),
      .q      (skew_q[r*BB +: BB])
    );

    assign out_w[r*bw +: bw] = skew_q[r*BB +: bw];
    assign inst_w[2*r +: 2]  = skew_q[r*BB + bw +: 2];
  end

endmodule

// File: tb/tb_west_feeder.sv
// Randomized bench for west_feeder against a phase-budget model.
// Issued words are predicted per cycle, then skewed by row index.
module tb_west_feeder;

  localparam int BW  = 4;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int CW  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              mode;
  logic              start;
  logic [CW-1:0]     num_act;
  logic              in_valid;
  logic              in_ready;
  logic [ROW*BW-1:0] in_data;
  logic [ROW*BW-1:0] out_w;
  logic [2*ROW-1:0]  inst_w;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  logic [1:0]        e_inst [0:4095];
  logic [ROW*BW-1:0] e_data [0:4095];

  int ob_load0, ob_exec0, ob_exec7, ob_exec_all, ob_bub0;
  int ob_ready, ob_ndone, ob_done_c, ob_first0, ob_first7;

  west_feeder #(
    .bw     (BW),
    .row    (ROW),
    .col    (COL),
    .cnt_bw (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .start    (start),
    .num_act  (num_act),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_w    (out_w),
    .inst_w   (inst_w),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; that cycle carries start.
  task automatic run_job(input bit m, input int n, input int vpct,
                         input int poke_c, input int stall_c);
    int load_left, gap_left, exec_left, last;
    bit v, xr, xbusy, xdone;
    logic [ROW*BW-1:0] d, xw;
    logic [2*ROW-1:0] xi;
    load_left = m ? 2*COL : COL;
    gap_left  = 1;
    exec_left = n;
    last      = 0;
    ob_load0 = 0; ob_exec0 = 0; ob_exec7 = 0; ob_exec_all = 0;
    ob_bub0 = 0; ob_ready = 0; ob_ndone = 0;
    ob_done_c = -1; ob_first0 = -1; ob_first7 = -1;
    start    = 1'b1;
    mode     = m;
    num_act  = n[CW-1:0];
    in_valid = 1'($urandom);
    in_data  = $urandom;
    e_inst[0] = 2'b00;
    e_data[0] = '0;
    for (int c = 1; c < 4000; c++) begin
      @(negedge clk);
      start   = (c == poke_c);
      mode    = 1'($urandom);
      num_act = CW'($urandom);
      if (stall_c > 0 && c >= stall_c && c < stall_c + 3) v = 1'b0;
      else v = ($urandom_range(99) < vpct);
      d = $urandom;
      in_valid = v;
      in_data  = d;
      xr = 1'b0;
      e_inst[c] = 2'b00;
      e_data[c] = '0;
      if (load_left > 0) begin
        xr = 1'b1;
        if (v) begin
          e_inst[c] = 2'b01;
          e_data[c] = d;
          load_left--;
        end
      end else if (gap_left > 0) begin
        gap_left--;
        if (n == 0) last = c;
      end else if (exec_left > 0) begin
        xr = 1'b1;
        if (v) begin
          e_inst[c] = 2'b10;
          e_data[c] = d;
          exec_left--;
          if (exec_left == 0) last = c;
        end
      end
      xw = '0;
      xi = '0;
      for (int r = 0; r < ROW; r++) begin
        int idx;
        idx = c - 1 - r;
        if (idx >= 1) begin
          xw[r*BW +: BW] = e_data[idx][r*BW +: BW];
          xi[2*r +: 2]   = e_inst[idx];
        end
      end
      xdone = (last != 0) && (c == last + ROW);
      xbusy = !xdone;
      checks++;
      if (in_ready !== xr) begin
        errors++;
        $display("FAIL in_ready c=%0d got %b want %b", c, in_ready, xr);
      end
      checks++;
      if (out_w !== xw) begin
        errors++;
        $display("FAIL out_w c=%0d got %h want %h", c, out_w, xw);
      end
      checks++;
      if (inst_w !== xi) begin
        errors++;
        $display("FAIL inst_w c=%0d got %h want %h", c, inst_w, xi);
      end
      checks++;
      if (busy !== xbusy) begin
        errors++;
        $display("FAIL busy c=%0d got %b want %b", c, busy, xbusy);
      end
      checks++;
      if (done !== xdone) begin
        errors++;
        $display("FAIL done c=%0d got %b want %b", c, done, xdone);
      end
      if (inst_w[1:0] == 2'b01) ob_load0++;
      if (inst_w[1:0] == 2'b10) ob_exec0++;
      if (inst_w[15:14] == 2'b10) ob_exec7++;
      for (int r = 0; r < ROW; r++)
        if (inst_w[2*r +: 2] == 2'b10) ob_exec_all++;
      if (c >= 2 && (last == 0 || c <= last + 1) && inst_w[1:0] == 2'b00)
        ob_bub0++;
      if (ob_first0 < 0 && inst_w[1:0] == 2'b01) ob_first0 = c;
      if (ob_first7 < 0 && inst_w[15:14] == 2'b01) ob_first7 = c;
      if (in_ready) ob_ready++;
      if (done === 1'b1) begin
        ob_ndone++;
        if (ob_done_c < 0) ob_done_c = c;
      end
      if (xdone) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout job got no end want done");
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({out_w, inst_w, in_ready, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_state got %h want 0",
               {out_w, inst_w, in_ready, busy, done});
    end
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    checks++;
    if ({out_w, inst_w, in_ready, busy, done} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset got %h want 0",
               {out_w, inst_w, in_ready, busy, done});
    end
  endtask

  task automatic test_basic;
    run_job(1'b0, 4, 100, 0, 0);
    checks++;
    if (ob_load0 !== 8) begin
      errors++;
      $display("FAIL basic_load got %0d want 8", ob_load0);
    end
    checks++;
    if (ob_exec0 !== 4 || ob_exec7 !== 4) begin
      errors++;
      $display("FAIL basic_exec got %0d/%0d want 4/4", ob_exec0, ob_exec7);
    end
    checks++;
    if (ob_first7 - ob_first0 !== 7) begin
      errors++;
      $display("FAIL basic_skew got %0d want 7", ob_first7 - ob_first0);
    end
    checks++;
    if (ob_done_c !== 21) begin
      errors++;
      $display("FAIL basic_done_cycle got %0d want 21", ob_done_c);
    end
    idle(3);
  endtask

  task automatic test_mode1;
    run_job(1'b1, 5, 100, 0, 0);
    checks++;
    if (ob_load0 !== 16) begin
      errors++;
      $display("FAIL mode1_load got %0d want 16", ob_load0);
    end
    checks++;
    if (ob_ready !== 21) begin
      errors++;
      $display("FAIL mode1_ready got %0d want 21", ob_ready);
    end
    idle(2);
  endtask

  task automatic test_stall;
    run_job(1'b0, 6, 100, 0, 12);
    checks++;
    if (ob_bub0 !== 4) begin
      errors++;
      $display("FAIL stall_bubbles got %0d want 4", ob_bub0);
    end
    checks++;
    if (ob_exec0 !== 6) begin
      errors++;
      $display("FAIL stall_exec got %0d want 6", ob_exec0);
    end
    idle(1);
  endtask

  task automatic test_start_ignored;
    run_job(1'b0, 6, 100, 12, 0);
    checks++;
    if (ob_exec7 !== 6 || ob_ndone !== 1) begin
      errors++;
      $display("FAIL start_ignored got %0d/%0d want 6/1", ob_exec7, ob_ndone);
    end
  endtask

  task automatic test_back_to_back;
    run_job(1'b0, 3, 80, 0, 0);
    run_job(1'b1, 2, 80, 0, 0);
    checks++;
    if (ob_load0 !== 16 || ob_exec7 !== 2) begin
      errors++;
      $display("FAIL b2b_zero_gap got %0d/%0d want 16/2", ob_load0, ob_exec7);
    end
    idle(1);
    run_job(1'b0, 3, 80, 0, 0);
    checks++;
    if (ob_load0 !== 8 || ob_ndone !== 1) begin
      errors++;
      $display("FAIL b2b_one_gap got %0d/%0d want 8/1", ob_load0, ob_ndone);
    end
    idle(2);
  endtask

  task automatic test_reset_mid_load;
    int nd;
    nd = 0;
    start    = 1'b1;
    mode     = 1'b0;
    num_act  = 8'd5;
    in_valid = 1'b1;
    in_data  = $urandom;
    repeat (4) begin
      @(negedge clk);
      start   = 1'b0;
      in_data = $urandom;
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({out_w, inst_w, in_ready, busy, done} !== '0) begin
      errors++;
      $display("FAIL abort_clear got %h want 0",
               {out_w, inst_w, in_ready, busy, done});
    end
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      in_valid = 1'b1;
      if (done === 1'b1) nd++;
    end
    checks++;
    if (nd !== 0 || busy !== 1'b0 || inst_w !== '0) begin
      errors++;
      $display("FAIL abort_idle got done=%0d busy=%b want 0 0", nd, busy);
    end
    run_job(1'b0, 5, 70, 0, 0);
    checks++;
    if (ob_exec7 !== 5 || ob_load0 !== 8 || ob_ndone !== 1) begin
      errors++;
      $display("FAIL abort_rerun got %0d/%0d/%0d want 5/8/1",
               ob_exec7, ob_load0, ob_ndone);
    end
    idle(1);
  endtask

  task automatic test_zero_act;
    run_job(1'b0, 0, 100, 0, 0);
    checks++;
    if (ob_exec_all !== 0) begin
      errors++;
      $display("FAIL zero_act_exec got %0d want 0", ob_exec_all);
    end
    checks++;
    if (ob_done_c !== 17) begin
      errors++;
      $display("FAIL zero_act_done got %0d want 17", ob_done_c);
    end
    idle(1);
  endtask

  task automatic test_max_act;
    run_job(1'b0, 255, 90, 0, 0);
    checks++;
    if (ob_exec0 !== 255 || ob_exec7 !== 255) begin
      errors++;
      $display("FAIL max_act got %0d/%0d want 255", ob_exec0, ob_exec7);
    end
    idle(1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) begin
      bit m;
      int n;
      m = 1'($urandom);
      n = $urandom_range(0, 40);
      run_job(m, n, $urandom_range(40, 100), 0, 0);
      checks++;
      if (ob_exec7 !== n || ob_ndone !== 1) begin
        errors++;
        $display("FAIL random_job%0d got %0d/%0d want %0d/1",
                 i, ob_exec7, ob_ndone, n);
      end
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    mode     = 1'b0;
    num_act  = '0;
    in_valid = 1'b0;
    in_data  = '0;
    test_reset;
    test_basic;
    test_mode1;
    test_stall;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid_load;
    test_zero_act;
    test_max_act;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/west_feeder.md
WEST_FEEDER -- requirements
Module: west_feeder

Interface
REQ-001 Parameter bw, default 4: width of one row's west data word (matches the tile in_w width).
REQ-002 Parameter row, default 8: number of array rows driven.
REQ-003 Parameter col, default 8: tiles per row, which sets the kernel-load length.
REQ-004 Parameter cnt_bw, default 8: width of the activation-count input.
REQ-005 Port clk, input, 1: single clock, rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port mode, input, 1: 0 = 4-bit act/4-bit weight; 1 = 2-bit act/4-bit weight; sampled on accepted start.
REQ-008 Port start, input, 1: one-cycle request to begin a load+execute job.
REQ-009 Port num_act, input, cnt_bw: number of activation words per row in the execute phase, sampled on accepted start.
REQ-010 Port in_valid, input, 1: the in_data word is valid.
REQ-011 Port in_ready, output, 1: the feeder accepts in_data this cycle.
REQ-012 Port in_data, input, row*bw: one word per row; row r occupies [r*bw +: bw].
REQ-013 Port out_w, output, row*bw: west data to the tiles; row r occupies [r*bw +: bw].
REQ-014 Port inst_w, output, 2*row: per-row instruction {execute, kernel_load}; row r occupies [2r +: 2].
REQ-015 Port busy, output, 1: high from accepted start until done.
REQ-016 Port done, output, 1: one-cycle pulse when the job fully leaves the skew lines.

Function
REQ-017 The FSM SHALL have five states: IDLE, LOAD, GAP, EXEC, DRAIN.
REQ-018 IDLE: start=1 is accepted; the block latches mode and num_act and moves to LOAD. A start in any other state is ignored.
REQ-019 LOAD: kernel length K = col when mode=0, or 2*col when mode=1. The block issues K words with inst=01, then moves to GAP.
REQ-020 GAP: the block issues exactly one bubble word (inst=00, data 0), then moves to EXEC. If num_act=0, it moves to DRAIN instead.
REQ-021 EXEC: the block issues num_act words with inst=10, then moves to DRAIN.
REQ-022 DRAIN: the block waits row-1 cycles, pulses done for one cycle, then returns to IDLE.
REQ-023 Issue handshake: in_ready = 1 only in LOAD or EXEC while words remain. A word issues only on in_valid && in_ready.
REQ-024 A cycle in LOAD or EXEC with in_valid=0 SHALL issue a bubble (inst=00, data 0). The phase counter does not advance.
REQ-025 Skew: row r's out_w and inst_w SHALL equal the issued word delayed by r cycles. Row 0 is registered with 1-cycle latency from the accepting edge.
REQ-026 Phase counters SHALL be col-sized (LOAD) and cnt_bw-wide (EXEC), with no wrap-around. num_act = 2^cnt_bw-1 SHALL be supported.
REQ-027 in_data SHALL pass through unmodified. In mode 1 each 4-bit word carries two packed 2-bit activations; the feeder does not interpret it.
REQ-028 busy SHALL fall in the same cycle that done pulses.
REQ-029 An accepted start SHALL be able to follow done with zero idle cycles in between.

Reset
REQ-030 When reset=0, asynchronously: state=IDLE; all counters 0; all skew registers 0; out_w=0, inst_w=0, in_ready=0, busy=0, done=0.
REQ-031 Reset asserted mid-job SHALL abort the job with no done pulse. After release the block waits in IDLE for a new start.

Structure
REQ-032 A shared package feeder_pkg SHALL hold the FSM state encoding, the instruction constants (INST_IDLE=00, INST_LOAD=01, INST_EXEC=10) and the GAP length constant (1).
REQ-033 One sub-module, skew_line, SHALL be used: a parameterised depth-d register delay for a (bw+2)-bit bundle, instantiated per row with d=r.

Verification
REQ-034 row=col=8, mode=0, num_act=4, in_valid held at 1: row 0 shows 8 cycles inst=01, 1 cycle inst=00, 4 cycles inst=10; row 7 shows the same 7 cycles later; done pulses 7 cycles after the last issue.
REQ-035 mode=1, col=8: row 0 shows 16 consecutive inst=01 words before the gap, and in_ready stays high for exactly 16 load cycles.
REQ-036 in_valid deasserted for 3 cycles mid-EXEC: exactly 3 inst=00 bubbles appear in row 0, the total count of inst=10 words stays num_act, and the words stay in order.
REQ-037 start pulsed during EXEC: no effect. start pulsed in the cycle after done: the new job is accepted.
REQ-038 reset driven low mid-LOAD: all outputs are 0 immediately, with no done pulse. After release, a fresh job completes with correct counts.
REQ-039 num_act=0: LOAD, then GAP, then DRAIN; done pulses, and no inst=10 words appear on any row.
